// File: rtl/spad_mac_sequencer_if.sv
// Bundle between the MAC sequencer, its two read-only scratchpads and the
// psum path. "slave" is the sequencer's view; "master" is the surrounding
// PE datapath (start/config source, spad read ports, psum consumer).
interface spad_mac_sequencer_if #(
  parameter int DATA_BITWIDTH    = 16,
  parameter int ADDRESS_BITWIDTH = 9,
  parameter int LEN_BITWIDTH     = 9,
  parameter int ACC_BITWIDTH     = 40
);
  // run control
  logic                        start;
  logic [ADDRESS_BITWIDTH-1:0] ifmap_base;
  logic [ADDRESS_BITWIDTH-1:0] wght_base;
  logic [LEN_BITWIDTH-1:0]     kernel_len;
  logic [ACC_BITWIDTH-1:0]     psum_init;
  logic                        busy;
  // ifmap scratchpad read port
  logic                        ifmap_rd_req;
  logic [ADDRESS_BITWIDTH-1:0] ifmap_rd_addr;
  logic [DATA_BITWIDTH-1:0]    ifmap_rd_data;
  // weight scratchpad read port
  logic                        wght_rd_req;
  logic [ADDRESS_BITWIDTH-1:0] wght_rd_addr;
  logic [DATA_BITWIDTH-1:0]    wght_rd_data;
  // psum output handshake
  logic [ACC_BITWIDTH-1:0]     psum_out;
  logic                        psum_valid;
  logic                        psum_ready;

  modport slave (
    input  start, ifmap_base, wght_base, kernel_len, psum_init,
    input  ifmap_rd_data, wght_rd_data, psum_ready,
    output busy, ifmap_rd_req, ifmap_rd_addr, wght_rd_req, wght_rd_addr,
    output psum_out, psum_valid
  );

  modport master (
    output start, ifmap_base, wght_base, kernel_len, psum_init,
    output ifmap_rd_data, wght_rd_data, psum_ready,
    input  busy, ifmap_rd_req, ifmap_rd_addr, wght_rd_req, wght_rd_addr,
    input  psum_out, psum_valid
  );
endinterface

// File: rtl/spad_mac_sequencer.sv
// Streams one kernel row out of the ifmap and weight scratchpads with paired
// reads, multiply-accumulates the returned words onto an initial psum and
// hands the result to the psum path over a valid/ready handshake.
module spad_mac_sequencer #(
  parameter int DATA_BITWIDTH    = 16,
  parameter int ADDRESS_BITWIDTH = 9,
  parameter int LEN_BITWIDTH     = 9,
  parameter int ACC_BITWIDTH     = 40
) (
  input  logic                  clk,
  input  logic                  reset,
  spad_mac_sequencer_if.slave   mac_if
);

  localparam int PROD_BITWIDTH = 2 * DATA_BITWIDTH;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN,
    OUT
  } state_e;

  state_e                      state_q,      state_d;
  logic [ADDRESS_BITWIDTH-1:0] ifmap_base_q, ifmap_base_d;
  logic [ADDRESS_BITWIDTH-1:0] wght_base_q,  wght_base_d;
  logic [LEN_BITWIDTH-1:0]     len_q,        len_d;
  logic [LEN_BITWIDTH-1:0]     idx_q,        idx_d;
  logic [ACC_BITWIDTH-1:0]     acc_q,        acc_d;
  // Spad data is valid one cycle after the request, so the request is
  // delayed by one cycle to mark which returned words are real.
  logic                        take_q,       take_d;

  logic                        fetch;
  logic signed [PROD_BITWIDTH-1:0] product;
  logic [ACC_BITWIDTH-1:0]     product_ext;

  assign fetch       = (state_q == FETCH);
  assign product     = $signed(mac_if.ifmap_rd_data) * $signed(mac_if.wght_rd_data);
  assign product_ext = {{(ACC_BITWIDTH-PROD_BITWIDTH){product[PROD_BITWIDTH-1]}}, product};

  // Both spads are always read together; addresses wrap at the spad size.
  assign mac_if.ifmap_rd_req  = fetch;
  assign mac_if.wght_rd_req   = fetch;
  assign mac_if.ifmap_rd_addr = ifmap_base_q + ADDRESS_BITWIDTH'(idx_q);
  assign mac_if.wght_rd_addr  = wght_base_q  + ADDRESS_BITWIDTH'(idx_q);
  assign mac_if.busy          = (state_q != IDLE);
  assign mac_if.psum_valid    = (state_q == OUT);
  assign mac_if.psum_out      = acc_q;

  // Next-state, datapath and run-parameter capture.
  always_comb begin
    // NOTE: every variable gets a default before any branch so that no path
    // leaves it unassigned, which would otherwise infer a latch.
    state_d      = state_q;
    ifmap_base_d = ifmap_base_q;
    wght_base_d  = wght_base_q;
    len_d        = len_q;
    idx_d        = idx_q;
    take_d       = fetch;
    acc_d        = acc_q;

    // Only words returned for an actual request are accumulated; filler
    // driven by an idle spad is ignored.
    if (take_q) begin
      acc_d = acc_q + product_ext;
    end

    unique case (state_q)
      IDLE: begin
        if (mac_if.start) begin
          ifmap_base_d = mac_if.ifmap_base;
          wght_base_d  = mac_if.wght_base;
          len_d        = mac_if.kernel_len;
          idx_d        = '0;
          acc_d        = mac_if.psum_init;
          state_d      = (mac_if.kernel_len == '0) ? OUT : FETCH;
        end
      end
      FETCH: begin
        if (idx_q == len_q - LEN_BITWIDTH'(1)) begin
          state_d = DRAIN;
        end else begin
          idx_d = idx_q + LEN_BITWIDTH'(1);
        end
      end
      // The final product arrives during this cycle.
      DRAIN: begin
        state_d = OUT;
      end
      OUT: begin
        if (mac_if.psum_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register; reset aborts any run in flight without emitting a psum.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (reset) begin
      state_q      <= IDLE;
      ifmap_base_q <= '0;
      wght_base_q  <= '0;
      len_q        <= '0;
      idx_q        <= '0;
      acc_q        <= '0;
      take_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      ifmap_base_q <= ifmap_base_d;
      wght_base_q  <= wght_base_d;
      len_q        <= len_d;
      idx_q        <= idx_d;
      acc_q        <= acc_d;
      take_q       <= take_d;
    end
  end

endmodule

// File: tb/tb_spad_mac_sequencer.sv
// Directed bench for spad_mac_sequencer: behavioural spads with filler on
// idle cycles, expected psums pushed to a scoreboard at start and popped
// when psum_valid rises.
module tb_spad_mac_sequencer;

  localparam int DW  = 16;
  localparam int AW  = 9;
  localparam int LW  = 9;
  localparam int ACW = 40;
  localparam int DEPTH = 1 << AW;

  logic clk;
  logic reset;

  spad_mac_sequencer_if #(
    .DATA_BITWIDTH(DW), .ADDRESS_BITWIDTH(AW),
    .LEN_BITWIDTH(LW), .ACC_BITWIDTH(ACW)
  ) mac_if ();

  spad_mac_sequencer #(
    .DATA_BITWIDTH(DW), .ADDRESS_BITWIDTH(AW),
    .LEN_BITWIDTH(LW), .ACC_BITWIDTH(ACW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .mac_if(mac_if)
  );

  logic [DW-1:0]  ifmap_mem [DEPTH];
  logic [DW-1:0]  wght_mem  [DEPTH];
  logic [ACW-1:0] sb_q [$];
  int checks = 0;
  int errors = 0;
  int req_count = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Spads: one-cycle read latency, nonzero filler when not requested.
  always @(posedge clk) begin
    mac_if.ifmap_rd_data <= mac_if.ifmap_rd_req ? ifmap_mem[mac_if.ifmap_rd_addr] : 16'hA5A5;
    mac_if.wght_rd_data  <= mac_if.wght_rd_req  ? wght_mem[mac_if.wght_rd_addr]   : 16'h5A5B;
  end

  always @(posedge clk) begin
    if (mac_if.ifmap_rd_req || mac_if.wght_rd_req) req_count++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference sum computed in 64-bit integer arithmetic, then truncated.
  function automatic logic [ACW-1:0] model(input int ib, input int wb, input int len,
                                           input logic [ACW-1:0] init);
    longint s;
    longint a;
    longint b;
    s = longint'($signed(init));
    for (int k = 0; k < len; k++) begin
      a = longint'($signed(ifmap_mem[(ib + k) % DEPTH]));
      b = longint'($signed(wght_mem[(wb + k) % DEPTH]));
      s = s + a * b;
    end
    return s[ACW-1:0];
  endfunction

  // One complete run. Called mid-cycle (after a negedge); hold = cycles of
  // psum_ready low in OUT, with a start pulse that must be ignored.
  task automatic run(input int ib, input int wb, input int len,
                     input logic [ACW-1:0] init, input logic [ACW-1:0] expected,
                     input int hold);
    logic [ACW-1:0] expv;
    mac_if.ifmap_base = AW'(ib);
    mac_if.wght_base  = AW'(wb);
    mac_if.kernel_len = LW'(len);
    mac_if.psum_init  = init;
    mac_if.psum_ready = (hold == 0);
    mac_if.start      = 1'b1;
    sb_q.push_back(expected);
    @(posedge clk); #1;
    mac_if.start = 1'b0;
    for (int k = 0; k < len; k++) begin
      @(negedge clk);
      check("ifmap_rd_req", 64'(mac_if.ifmap_rd_req), 64'd1);
      check("wght_rd_req", 64'(mac_if.wght_rd_req), 64'd1);
      check("ifmap_rd_addr", 64'(mac_if.ifmap_rd_addr), 64'((ib + k) % DEPTH));
      check("wght_rd_addr", 64'(mac_if.wght_rd_addr), 64'((wb + k) % DEPTH));
    end
    if (len > 0) begin
      @(negedge clk);
      check("drain_rd_req", 64'(mac_if.ifmap_rd_req | mac_if.wght_rd_req), 64'd0);
      check("drain_valid", 64'(mac_if.psum_valid), 64'd0);
      check("drain_busy", 64'(mac_if.busy), 64'd1);
    end
    @(negedge clk);
    check("valid_rise", 64'(mac_if.psum_valid), 64'd1);
    expv = sb_q.pop_front();
    check("psum_out", 64'(mac_if.psum_out), 64'(expv));
    for (int h = 0; h < hold; h++) begin
      mac_if.start = (h == 1);
      @(negedge clk);
      check("hold_valid", 64'(mac_if.psum_valid), 64'd1);
      check("hold_psum", 64'(mac_if.psum_out), 64'(expv));
      check("hold_busy", 64'(mac_if.busy), 64'd1);
      check("hold_rd_req", 64'(mac_if.ifmap_rd_req), 64'd0);
    end
    mac_if.start      = 1'b0;
    mac_if.psum_ready = 1'b1;
    @(negedge clk);
    check("after_accept_valid", 64'(mac_if.psum_valid), 64'd0);
    check("after_accept_busy", 64'(mac_if.busy), 64'd0);
  endtask

  initial begin
    int rc;
    logic [ACW-1:0] e;
    reset             = 1'b1;
    mac_if.start      = 1'b0;
    mac_if.ifmap_base = '0;
    mac_if.wght_base  = '0;
    mac_if.kernel_len = '0;
    mac_if.psum_init  = '0;
    mac_if.psum_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      ifmap_mem[i] = DW'($urandom);
      wght_mem[i]  = DW'($urandom);
    end
    ifmap_mem[0] = 16'd1; ifmap_mem[1] = 16'd2; ifmap_mem[2] = 16'd3;
    wght_mem[100] = 16'd4; wght_mem[101] = 16'd5; wght_mem[102] = 16'd6;
    ifmap_mem[10] = 16'hFFFE; wght_mem[200] = 16'd3;
    ifmap_mem[510] = 16'h8000; wght_mem[0] = 16'h8000;
    ifmap_mem[511] = 16'h7FFF; wght_mem[1] = 16'h8000;

    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset_busy", 64'(mac_if.busy), 64'd0);
    check("reset_rd_req", 64'(mac_if.ifmap_rd_req | mac_if.wght_rd_req), 64'd0);
    check("reset_valid", 64'(mac_if.psum_valid), 64'd0);
    check("reset_psum", 64'(mac_if.psum_out), 64'd0);
    check("reset_addr", 64'({mac_if.ifmap_rd_addr, mac_if.wght_rd_addr}), 64'd0);

    // Basic row, then back-to-back signed case.
    run(0, 100, 3, 40'd0, 40'd32, 0);
    run(10, 200, 1, 40'd10, 40'd4, 0);

    // Address wrap on the ifmap spad with extreme operands.
    e = model(510, 0, 4, 40'h12_3456_789A);
    run(510, 0, 4, 40'h12_3456_789A, e, 0);

    // Backpressure with an ignored start pulse.
    e = model(50, 60, 2, 40'hFF_FFFF_FF00);
    run(50, 60, 2, 40'hFF_FFFF_FF00, e, 5);

    // Zero-length run: no requests at all.
    rc = req_count;
    run(7, 8, 0, -40'sd7, -40'sd7, 0);
    check("len0_no_req", 64'(req_count - rc), 64'd0);

    // Abort mid-run with reset.
    mac_if.ifmap_base = AW'(20);
    mac_if.wght_base  = AW'(300);
    mac_if.kernel_len = LW'(8);
    mac_if.psum_init  = 40'd999;
    mac_if.start      = 1'b1;
    @(posedge clk); #1;
    mac_if.start = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("abort_rd_req", 64'(mac_if.ifmap_rd_req | mac_if.wght_rd_req), 64'd0);
    check("abort_busy", 64'(mac_if.busy), 64'd0);
    check("abort_valid", 64'(mac_if.psum_valid), 64'd0);
    check("abort_acc", 64'(mac_if.psum_out), 64'd0);
    @(negedge clk);
    check("abort_idle_acc", 64'(mac_if.psum_out), 64'd0);
    e = model(30, 310, 2, 40'd5);
    run(30, 310, 2, 40'd5, e, 0);

    check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
